// File: rtl/sm4_pkg.sv
// Shared SM4 definitions: controller state encoding, round count, mode codes and word reversal R.
package sm4_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} sm4State_t;

    localparam int   SM4_NROUNDS = 32;
    localparam logic SM4_ENC     = 1'b0;
    localparam logic SM4_DEC     = 1'b1;

    function automatic logic [127:0] wordReverse(input logic [127:0] x);
        return {x[31:0], x[63:32], x[95:64], x[127:96]};
    endfunction

endpackage

// File: rtl/sm4_round_cnt.sv
// Round counter with terminal flag; maps the count to a key-store index
// (forward for encrypt, reversed for decrypt).
module sm4_round_cnt
    import sm4_pkg::*;
#(
    parameter int NROUNDS = SM4_NROUNDS
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clr,
    input  logic       i_inc,
    input  logic       i_mode,
    output logic       o_last,
    output logic [4:0] o_rk_idx
);

    localparam logic [4:0] LAST_CNT = 5'(NROUNDS - 1);

    logic [4:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + 5'd1;
        end
    end

    assign o_last   = (r_cnt == LAST_CNT);
    assign o_rk_idx = (i_mode == SM4_DEC) ? (LAST_CNT - r_cnt) : r_cnt;

endmodule

// File: rtl/sm4_round_ctrl.sv
// Iterative SM4 round sequencer between the bus adapter and the external round unit / key store.
// Optional WAIT watchdog with o_err output: define SM4_ROUND_CTRL_WDOG_EN.
module sm4_round_ctrl
    import sm4_pkg::*;
#(
    parameter int RF_LAT  = 5,
    parameter int NROUNDS = SM4_NROUNDS
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic         i_mode,
    input  logic [127:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [127:0] o_data,
    output logic [4:0]   o_rk_idx,
    input  logic [31:0]  i_rk,
    output logic         o_rf_valid,
    output logic [127:0] o_rf_data,
    output logic [31:0]  o_rf_rk,
    input  logic         i_rf_valid,
    input  logic [127:0] i_rf_next_data
`ifdef SM4_ROUND_CTRL_WDOG_EN
    ,
    output logic         o_err
`endif
);

    sm4State_t    r_state;
    logic         r_mode;
    logic         r_valid;
    logic         r_rfValid;
    logic [127:0] r_blk;
    logic [127:0] r_data;
    logic [31:0]  r_rfRk;

    logic         w_accept;
    logic         w_last;
    logic         w_cntClr;
    logic         w_cntInc;
    logic         w_timeout;
    logic [4:0]   w_rkIdx;

    if (RF_LAT < 1 || RF_LAT > 250) begin : g_badRfLat
        $error("sm4_round_ctrl: RF_LAT must lie in 1..250");
    end

`ifdef SM4_ROUND_CTRL_WDOG_EN
    // The timer counts WAIT cycles; the result may still land on the last allowed cycle.
    localparam logic [7:0] WDOG_LIMIT = 8'(RF_LAT + 3);

    logic [7:0] r_wdog;
    logic       r_err;

    assign w_timeout = (r_state == WAIT) && !i_rf_valid && (r_wdog == WDOG_LIMIT);
    assign o_err     = r_err;
`else
    assign w_timeout = 1'b0;
`endif

    assign w_accept = (r_state == IDLE) && i_valid;
    assign w_cntClr = w_accept || w_timeout;
    assign w_cntInc = (r_state == WAIT) && i_rf_valid && !w_last;

    sm4_round_cnt #(
        .NROUNDS (NROUNDS)
    ) u_cnt (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clr    (w_cntClr),
        .i_inc    (w_cntInc),
        .i_mode   (r_mode),
        .o_last   (w_last),
        .o_rk_idx (w_rkIdx)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_mode    <= SM4_ENC;
            r_valid   <= 1'b0;
            r_rfValid <= 1'b0;
            r_blk     <= '0;
            r_data    <= '0;
            r_rfRk    <= '0;
`ifdef SM4_ROUND_CTRL_WDOG_EN
            r_wdog    <= '0;
            r_err     <= 1'b0;
`endif
        end else begin
            r_rfValid <= 1'b0;
`ifdef SM4_ROUND_CTRL_WDOG_EN
            r_err     <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_blk     <= i_data;
                        r_mode    <= i_mode;
                        r_rfValid <= 1'b1;
                        r_state   <= ISSUE;
                    end
                end
                // The key store answers combinationally to o_rk_idx during the issue cycle.
                ISSUE: begin
                    r_rfRk  <= i_rk;
                    r_state <= WAIT;
`ifdef SM4_ROUND_CTRL_WDOG_EN
                    r_wdog  <= '0;
`endif
                end
                WAIT: begin
                    if (i_rf_valid) begin
                        r_blk <= i_rf_next_data;
                        if (w_last) begin
                            r_data  <= wordReverse(i_rf_next_data);
                            r_valid <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_rfValid <= 1'b1;
                            r_state   <= ISSUE;
                        end
                    end
`ifdef SM4_ROUND_CTRL_WDOG_EN
                    else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_blk   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_wdog <= r_wdog + 8'd1;
                    end
`endif
                end
                DONE: begin
                    if (i_ready) begin
                        r_valid <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_ready    = (r_state == IDLE) && !i_rst;
    assign o_valid    = r_valid;
    assign o_data     = r_data;
    assign o_rk_idx   = w_rkIdx;
    assign o_rf_valid = r_rfValid;
    assign o_rf_data  = r_blk;
    assign o_rf_rk    = r_rfRk;

endmodule

// File: tb/tb_sm4_round_ctrl.sv
// Self-checking bench for sm4_round_ctrl: models the round unit and key store, checks against an SM4 reference.
// Define SM4_ROUND_CTRL_WDOG_EN to also exercise the watchdog.
module tb_sm4_round_ctrl;

    localparam int RF_LAT = 5;
    localparam int NR     = 32;
    localparam int LAT    = NR * (RF_LAT + 1) + 1;

    localparam logic [127:0] MK     = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] VEC_PT = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] VEC_CT = 128'h681edf34d206965e86b3e94f536e4246;

    localparam logic [31:0] FK [4] = '{32'ha3b1bac6, 32'h56aa3350, 32'h677d9197, 32'hb27022dc};

    localparam logic [127:0] SBOX_ROWS [16] = '{
        128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_valid;
    logic         o_ready;
    logic         i_mode;
    logic [127:0] i_data;
    logic         o_valid;
    logic         i_ready;
    logic [127:0] o_data;
    logic [4:0]   o_rk_idx;
    logic [31:0]  i_rk;
    logic         o_rf_valid;
    logic [127:0] o_rf_data;
    logic [31:0]  o_rf_rk;
    logic         i_rf_valid;
    logic [127:0] i_rf_next_data;
`ifdef SM4_ROUND_CTRL_WDOG_EN
    logic         o_err;
`endif

    logic [31:0] rk [32];
    int          cyc = 0;
    int          checks = 0;
    int          passes = 0;
    int          cA = 0;
    logic        blkMode = 1'b0;
    int          pulseTotal = 0;
    int          pulseBase = 0;
    int          staleReq = 0;
    int          suppressRound = -1;
    int          tIssueSup = 0;

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    assign i_rk = rk[o_rk_idx];

    sm4_round_ctrl #(
        .RF_LAT  (RF_LAT),
        .NROUNDS (NR)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_valid        (i_valid),
        .o_ready        (o_ready),
        .i_mode         (i_mode),
        .i_data         (i_data),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_data         (o_data),
        .o_rk_idx       (o_rk_idx),
        .i_rk           (i_rk),
        .o_rf_valid     (o_rf_valid),
        .o_rf_data      (o_rf_data),
        .o_rf_rk        (o_rf_rk),
        .i_rf_valid     (i_rf_valid),
        .i_rf_next_data (i_rf_next_data)
`ifdef SM4_ROUND_CTRL_WDOG_EN
        ,
        .o_err          (o_err)
`endif
    );

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [127:0] row;
        int           col;
        row = SBOX_ROWS[b[7:4]];
        col = 15 - int'(b[3:0]);
        return row[col*8 +: 8];
    endfunction

    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] tau(input logic [31:0] a);
        return {sbox(a[31:24]), sbox(a[23:16]), sbox(a[15:8]), sbox(a[7:0])};
    endfunction

    function automatic logic [31:0] tRound(input logic [31:0] x);
        logic [31:0] b;
        b = tau(x);
        return b ^ rol(b, 2) ^ rol(b, 10) ^ rol(b, 18) ^ rol(b, 24);
    endfunction

    function automatic logic [31:0] tKey(input logic [31:0] x);
        logic [31:0] b;
        b = tau(x);
        return b ^ rol(b, 13) ^ rol(b, 23);
    endfunction

    // One SM4 round: {X0..X3} -> {X1..X4}.
    function automatic logic [127:0] roundStep(input logic [127:0] s, input logic [31:0] k);
        logic [31:0] x0, x1, x2, x3;
        {x0, x1, x2, x3} = s;
        return {x1, x2, x3, x0 ^ tRound(x1 ^ x2 ^ x3 ^ k)};
    endfunction

    function automatic logic [127:0] sm4Ref(input logic [127:0] d, input logic m);
        logic [127:0] s;
        s = d;
        for (int r = 0; r < NR; r++) s = roundStep(s, rk[m ? (NR - 1 - r) : r]);
        return {s[31:0], s[63:32], s[95:64], s[127:96]};
    endfunction

    function automatic logic [127:0] randBlock();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic keyExpand(input logic [127:0] mk);
        logic [31:0] k [36];
        logic [31:0] ck;
        for (int i = 0; i < 4; i++) k[i] = mk[127 - 32*i -: 32] ^ FK[i];
        for (int i = 0; i < NR; i++) begin
            for (int j = 0; j < 4; j++) ck[31 - 8*j -: 8] = 8'((4*i + j) * 7);
            k[i+4] = k[i] ^ tKey(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
            rk[i]  = k[i+4];
        end
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs === exp) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    // Round unit and key-timing monitor: results come back RF_LAT cycles after each issue.
    initial begin : roundUnit
        logic         rkPend;
        logic [127:0] pData;
        logic [127:0] nextData;
        logic [4:0]   expIdx;
        int           cd;
        int           pRound;
        int           staleSeen;
        int           k;
        rkPend = 1'b0; pData = '0; nextData = '0; expIdx = '0;
        cd = 0; pRound = -2; staleSeen = 0;
        i_rf_valid = 1'b0;
        i_rf_next_data = '0;
        forever begin
            @(negedge i_clk);
            i_rf_valid = 1'b0;
            if (i_rst) begin
                rkPend = 1'b0;
                cd = 0;
            end else begin
                if (staleReq != staleSeen) begin
                    staleSeen = staleReq;
                    i_rf_valid = 1'b1;
                    i_rf_next_data = {4{32'hdeadbeef}};
                end
                if (rkPend) begin
                    checkOutput("rfRk", o_rf_rk, rk[expIdx]);
                    nextData = roundStep(pData, o_rf_rk);
                    rkPend = 1'b0;
                end
                if (cd > 0) begin
                    cd--;
                    if (cd == 0 && pRound != suppressRound) begin
                        i_rf_valid = 1'b1;
                        i_rf_next_data = nextData;
                    end
                end
                if (o_rf_valid) begin
                    k = pulseTotal - pulseBase;
                    expIdx = blkMode ? 5'(NR - 1 - k) : 5'(k);
                    checkOutput("rkIdx", o_rk_idx, expIdx);
                    pData = o_rf_data;
                    pRound = k;
                    if (k == suppressRound) tIssueSup = cyc;
                    pulseTotal++;
                    rkPend = 1'b1;
                    cd = RF_LAT;
                end
            end
        end
    end

    task automatic markAccept(input logic m);
        cA = cyc;
        blkMode = m;
        pulseBase = pulseTotal;
    endtask

    task automatic applyStimulus(input logic [127:0] d, input logic m);
        int n;
        i_data = d;
        i_mode = m;
        i_valid = 1'b1;
        n = 0;
        while (!o_ready && n < 300) begin
            @(negedge i_clk);
            n++;
        end
        checkOutput("acceptReady", o_ready, 1);
        markAccept(m);
        @(negedge i_clk);
        i_valid = 1'b0;
        i_data = randBlock();
        i_mode = 1'($urandom());
    endtask

    task automatic waitResult(input logic [127:0] exp, input string tag);
        int n;
        n = 0;
        while (!o_valid && n < 400) begin
            @(negedge i_clk);
            n++;
        end
        checkOutput({tag, "Valid"}, o_valid, 1);
        checkOutput({tag, "Latency"}, cyc - cA, LAT);
        checkOutput({tag, "Data"}, o_data, exp);
        checkOutput({tag, "Pulses"}, pulseTotal - pulseBase, NR);
    endtask

    task automatic finishOut(input int stall);
        i_ready = 1'b0;
        repeat (stall) begin
            @(negedge i_clk);
            checkOutput("stallValid", o_valid, 1);
        end
        i_ready = 1'b1;
        @(negedge i_clk);
        i_ready = 1'b0;
        checkOutput("hsValid", o_valid, 0);
        checkOutput("hsReady", o_ready, 1);
    endtask

    initial begin : globalTimeout
        #300000;
        $display("[TB] FAIL globalTimeout: got no finish, expected finish before %0d cycles", cyc);
        $fatal(1, "[TB] simulation timed out");
    end

    initial begin : main
        logic [127:0] d;
        logic         m;
        int           n;
        logic         sawValid;
        i_rst = 1'b1; i_valid = 1'b0; i_mode = 1'b0; i_data = '0; i_ready = 1'b0;
        keyExpand(MK);
        repeat (3) @(negedge i_clk);
        checkOutput("rstReady", o_ready, 0);
        checkOutput("rstValid", o_valid, 0);
        checkOutput("rstData", o_data, 0);
        checkOutput("rstRkIdx", o_rk_idx, 0);
        checkOutput("rstRfValid", o_rf_valid, 0);
        checkOutput("rstRfData", o_rf_data, 0);
        checkOutput("rstRfRk", o_rf_rk, 0);
        i_rst = 1'b0;
        @(negedge i_clk);
        checkOutput("idleReady", o_ready, 1);

        $display("[TB] encrypt reference vector");
        applyStimulus(VEC_PT, 1'b0);
        waitResult(VEC_CT, "enc");

        $display("[TB] backpressure then back-to-back decrypt");
        i_data = VEC_CT;
        i_mode = 1'b1;
        i_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge i_clk);
            checkOutput("bpValid", o_valid, 1);
            checkOutput("bpData", o_data, VEC_CT);
            checkOutput("bpReady", o_ready, 0);
        end
        i_ready = 1'b1;
        @(negedge i_clk);
        i_ready = 1'b0;
        checkOutput("bpRelValid", o_valid, 0);
        checkOutput("bpIdleReady", o_ready, 1);
        markAccept(1'b1);
        @(negedge i_clk);
        i_valid = 1'b0;
        checkOutput("b2bAccepted", o_ready, 0);
        waitResult(VEC_PT, "dec");
        finishOut(0);

        $display("[TB] reset during round 10");
        applyStimulus(randBlock(), 1'b0);
        n = 0;
        while ((pulseTotal - pulseBase) < 11 && n < 300) begin
            @(negedge i_clk);
            n++;
        end
        checkOutput("abortRound", pulseTotal - pulseBase, 11);
        repeat (2) @(negedge i_clk);
        #2 i_rst = 1'b1;
        #1;
        checkOutput("abortReady", o_ready, 0);
        checkOutput("abortValid", o_valid, 0);
        checkOutput("abortData", o_data, 0);
        checkOutput("abortRkIdx", o_rk_idx, 0);
        checkOutput("abortRfValid", o_rf_valid, 0);
        checkOutput("abortRfData", o_rf_data, 0);
        checkOutput("abortRfRk", o_rf_rk, 0);
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        staleReq++;
        repeat (3) @(negedge i_clk);
        checkOutput("staleReady", o_ready, 1);
        checkOutput("staleRfValid", o_rf_valid, 0);
        checkOutput("staleRfData", o_rf_data, 0);
        checkOutput("staleValid", o_valid, 0);
        d = randBlock();
        applyStimulus(d, 1'b0);
        waitResult(sm4Ref(d, 1'b0), "fresh");
        finishOut(1);

        $display("[TB] random blocks");
        for (int b = 0; b < 4; b++) begin
            d = randBlock();
            m = 1'($urandom());
            applyStimulus(d, m);
            waitResult(sm4Ref(d, m), "rand");
            finishOut(int'($urandom_range(0, 4)));
        end

`ifdef SM4_ROUND_CTRL_WDOG_EN
        $display("[TB] watchdog on round 3");
        suppressRound = 3;
        sawValid = 1'b0;
        applyStimulus(randBlock(), 1'b0);
        n = 0;
        while (!o_err && n < 300) begin
            @(negedge i_clk);
            if (o_valid) sawValid = 1'b1;
            n++;
        end
        checkOutput("wdogErr", o_err, 1);
        checkOutput("wdogTime", cyc - tIssueSup, RF_LAT + 5);
        @(negedge i_clk);
        checkOutput("wdogPulse", o_err, 0);
        checkOutput("wdogIdle", o_ready, 1);
        checkOutput("wdogRfData", o_rf_data, 0);
        repeat (10) begin
            @(negedge i_clk);
            if (o_valid) sawValid = 1'b1;
        end
        checkOutput("wdogNoValid", sawValid, 0);
        suppressRound = -1;
`else
        sawValid = 1'b0;
        checkOutput("endIdle", o_ready, 1);
        checkOutput("endNoValid", o_valid | sawValid, 0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
